// File: rtl/uart_core_param_if.sv
// uart_core_param_if
//   Parallel-side bundle of one UART channel.
//   master: bus logic (drives tx_valid/tx_data/rx_ready)
//   slave : uart_core_param (drives tx_ready/tx_done and all rx_* outputs)
//
// Handshake semantics (both directions):
//   A word moves on a rising sys_clk edge where valid && ready are both 1.
//   The producer holds valid and data stable until that edge. Neither
//   tx_ready nor rx_valid depends combinationally on its partner signal.
interface uart_core_param_if #(
    parameter int DATA_W = 8
);
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] tx_data;
    logic              tx_done;
    logic              rx_valid;
    logic              rx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_parity_err;
    logic              rx_frame_err;
    logic              rx_overrun;

    modport master (
        output tx_valid, tx_data, rx_ready,
        input  tx_ready, tx_done, rx_valid, rx_data,
               rx_parity_err, rx_frame_err, rx_overrun
    );

    modport slave (
        input  tx_valid, tx_data, rx_ready,
        output tx_ready, tx_done, rx_valid, rx_data,
               rx_parity_err, rx_frame_err, rx_overrun
    );
endinterface

// File: rtl/uart_core_param.sv
// uart_core_param
//   Parametrised full-duplex UART channel: TX serialiser and oversampling RX
//   with a one-word holding register, parity/framing/overrun flags and an
//   internal loopback path.
// Ports
//   sys_clk, sys_rst_l : clock, asynchronous active-low reset
//   uart_tx            : serial out (idle high, registered)
//   uart_rx            : serial in (asynchronous, synchronised internally)
//   loopback           : 1 = RX listens to uart_tx instead of uart_rx
//   bus                : parallel TX/RX handshake bundle (slave side)
//   tx_fsm, rx_fsm     : debug view of the FSM states
//                        (0 IDLE, 1 START, 2 DATA, 3 PARITY, 4 STOP)
module uart_core_param #(
    parameter int DATA_W     = 8,
    parameter int BIT_CLKS   = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                sys_clk,
    input  logic                sys_rst_l,
    output logic                uart_tx,
    input  logic                uart_rx,
    input  logic                loopback,
    uart_core_param_if.slave    bus,
    output logic [2:0]          tx_fsm,
    output logic [2:0]          rx_fsm
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    localparam int CNT_W = $clog2(BIT_CLKS);
    localparam int IDX_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CLKS - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(BIT_CLKS - 2);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BIT_CLKS / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic             PAR_ODD   = (PARITY_ODD != 0);

    // ---------------- TX ----------------
    state_t            tx_state;
    logic [CNT_W-1:0]  tx_cnt;
    logic [IDX_W-1:0]  tx_idx;
    logic              tx_stop_idx;
    logic [DATA_W-1:0] tx_shift;
    logic              tx_par;

    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            tx_state    <= S_IDLE;
            tx_cnt      <= '0;
            tx_idx      <= '0;
            tx_stop_idx <= 1'b0;
            tx_shift    <= '0;
            tx_par      <= 1'b0;
            uart_tx     <= 1'b1;
            bus.tx_ready <= 1'b1;
            bus.tx_done  <= 1'b0;
        end else begin
            bus.tx_done <= 1'b0;
            case (tx_state)
                S_IDLE: begin
                    if (bus.tx_valid && bus.tx_ready) begin
                        tx_shift     <= bus.tx_data;
                        tx_par       <= (^bus.tx_data) ^ PAR_ODD;
                        uart_tx      <= 1'b0;
                        bus.tx_ready <= 1'b0;
                        tx_cnt       <= '0;
                        tx_state     <= S_START;
                    end
                end
                S_START: begin
                    if (tx_cnt == CNT_LAST) begin
                        tx_cnt   <= '0;
                        tx_idx   <= '0;
                        uart_tx  <= tx_shift[0];
                        tx_shift <= {1'b0, tx_shift[DATA_W-1:1]};
                        tx_state <= S_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (tx_cnt == CNT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_idx == IDX_LAST) begin
                            if (PARITY_EN != 0) begin
                                uart_tx  <= tx_par;
                                tx_state <= S_PARITY;
                            end else begin
                                uart_tx     <= 1'b1;
                                tx_stop_idx <= 1'b0;
                                tx_state    <= S_STOP;
                            end
                        end else begin
                            tx_idx   <= tx_idx + 1'b1;
                            uart_tx  <= tx_shift[0];
                            tx_shift <= {1'b0, tx_shift[DATA_W-1:1]};
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (tx_cnt == CNT_LAST) begin
                        tx_cnt      <= '0;
                        uart_tx     <= 1'b1;
                        tx_stop_idx <= 1'b0;
                        tx_state    <= S_STOP;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    // tx_done is registered, so raise it one cycle early to
                    // land exactly on the final stop cycle.
                    if (tx_cnt == CNT_PRE && tx_stop_idx == STOP_LAST)
                        bus.tx_done <= 1'b1;
                    if (tx_cnt == CNT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_stop_idx == STOP_LAST) begin
                            bus.tx_ready <= 1'b1;
                            tx_state     <= S_IDLE;
                        end else begin
                            tx_stop_idx <= 1'b1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: tx_state <= S_IDLE;
            endcase
        end
    end

    // ---------------- RX ----------------
    logic [1:0]        rx_sync;
    logic              rx_line;
    state_t            rx_state;
    logic [CNT_W-1:0]  rx_cnt;
    logic [IDX_W-1:0]  rx_idx;
    logic [DATA_W-1:0] rx_shift;
    logic              rx_perr;
    logic              rx_load;
    logic              rx_accept;

    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) rx_sync <= 2'b11;
        else            rx_sync <= {rx_sync[0], loopback ? uart_tx : uart_rx};
    end

    assign rx_line = rx_sync[1];

    always_comb begin
        rx_load   = (rx_state == S_STOP) && (rx_cnt == CNT_LAST);
        rx_accept = bus.rx_valid && bus.rx_ready;
    end

    // Sampling points sit BIT_CLKS apart starting from the start-bit midpoint.
    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_shift <= '0;
            rx_perr  <= 1'b0;
        end else begin
            case (rx_state)
                S_IDLE: begin
                    if (!rx_line) begin
                        rx_cnt   <= '0;
                        rx_state <= S_START;
                    end
                end
                S_START: begin
                    if (rx_cnt == CNT_HALF) begin
                        rx_cnt <= '0;
                        if (rx_line) begin
                            rx_state <= S_IDLE;
                        end else begin
                            rx_idx   <= '0;
                            rx_perr  <= 1'b0;
                            rx_state <= S_DATA;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (rx_cnt == CNT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_line, rx_shift[DATA_W-1:1]};
                        if (rx_idx == IDX_LAST)
                            rx_state <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        else
                            rx_idx <= rx_idx + 1'b1;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (rx_cnt == CNT_LAST) begin
                        rx_cnt   <= '0;
                        // Received bit must equal ^data ^ PARITY_ODD.
                        rx_perr  <= rx_line ^ (^rx_shift) ^ PAR_ODD;
                        rx_state <= S_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    // Leave at the stop midpoint so the next start edge can
                    // be found during the remaining half bit.
                    if (rx_cnt == CNT_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= S_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_state <= S_IDLE;
            endcase
        end
    end

    // Holding register. rx_overrun can only be set while rx_valid is 1 and
    // is cleared together with rx_valid, so on a load it simply records
    // whether an unaccepted word is being replaced.
    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            bus.rx_valid      <= 1'b0;
            bus.rx_data       <= '0;
            bus.rx_parity_err <= 1'b0;
            bus.rx_frame_err  <= 1'b0;
            bus.rx_overrun    <= 1'b0;
        end else if (rx_load) begin
            bus.rx_valid      <= 1'b1;
            bus.rx_data       <= rx_shift;
            bus.rx_parity_err <= rx_perr;
            bus.rx_frame_err  <= !rx_line;
            bus.rx_overrun    <= bus.rx_valid && !bus.rx_ready;
        end else if (rx_accept) begin
            bus.rx_valid   <= 1'b0;
            bus.rx_overrun <= 1'b0;
        end
    end

    assign tx_fsm = tx_state;
    assign rx_fsm = rx_state;
endmodule
